// File: rtl/copr_mem_reader.sv
// copr_mem_reader: walks N_PORTS input ports in order, bursting port_len[p] RAM words from
// port_base[p] into each port through a send/rdy handshake behind a 2-entry skid FIFO.
module copr_mem_reader #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [N_PORTS*ADDR_W-1:0]   i_port_base,
    input  logic [N_PORTS*LEN_W-1:0]    i_port_len,
    output logic                        o_mem_en,
    output logic [ADDR_W-1:0]           o_mem_addr,
    input  logic [DATA_W-1:0]           i_mem_data,
    output logic [DATA_W-1:0]           o_out_data,
    output logic [N_PORTS-1:0]          o_out_send,
    input  logic [N_PORTS-1:0]          i_out_rdy,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int P_W = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    typedef enum logic [2:0] {IDLE, SEL, STREAM, FLUSH, DONE} state_t;
    state_t                      r_state, w_next;
    logic [N_PORTS*ADDR_W-1:0]   r_base;
    logic [N_PORTS*LEN_W-1:0]    r_len;
    logic [P_W-1:0]              r_p;
    logic [LEN_W-1:0]            r_issue_cnt, r_xfer_cnt;
    logic                        r_inflight;
    logic [DATA_W-1:0]           r_fifo [2];
    logic                        r_wr_ptr, r_rd_ptr;
    logic [1:0]                  r_count;
    logic [ADDR_W-1:0]           w_base;
    logic [LEN_W-1:0]            w_len;
    logic                        w_last, w_pop, w_issue;
    logic [2:0]                  w_occ;

    assign w_base = r_base[int'(r_p)*ADDR_W +: ADDR_W];
    assign w_len  = r_len[int'(r_p)*LEN_W +: LEN_W];
    assign w_last = r_p == P_W'(N_PORTS-1);
    assign w_pop  = (r_count != 2'd0) && i_out_rdy[r_p];
    // Counting the same-cycle pop lets a full FIFO refill every cycle without ever exceeding two slots.
    assign w_occ   = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == STREAM) && (r_issue_cnt < w_len) && (w_occ < 3'd2);

    assign o_mem_en   = w_issue;
    assign o_mem_addr = w_issue ? w_base + ADDR_W'(r_issue_cnt) : '0;
    assign o_out_data = r_fifo[r_rd_ptr];
    assign o_out_send = (r_count != 2'd0) ? N_PORTS'(1) << r_p : '0;
    assign o_busy     = r_state != IDLE;
    assign o_done     = r_state == DONE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? SEL : IDLE;
            SEL:     w_next = (w_len != '0) ? STREAM : (w_last ? DONE : SEL);
            STREAM:  w_next = (r_issue_cnt == w_len) ? FLUSH : STREAM;
            FLUSH:   w_next = (r_xfer_cnt == w_len && r_count == 2'd0 && !r_inflight) ?
                              (w_last ? DONE : SEL) : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_p         <= '0;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            r_count    <= r_count + 2'(r_inflight) - 2'(w_pop);
            if (r_state == IDLE && i_start) begin
                r_base <= i_port_base;
                r_len  <= i_port_len;
                r_p    <= '0;
            end
            if (r_state == SEL) begin
                r_issue_cnt <= '0;
                r_xfer_cnt  <= '0;
            end
            if ((r_state == SEL && w_len == '0 && !w_last) || (r_state == FLUSH && w_next == SEL))
                r_p <= r_p + P_W'(1);
            if (w_issue)
                r_issue_cnt <= r_issue_cnt + LEN_W'(1);
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= i_mem_data;
                r_wr_ptr         <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr   <= !r_rd_ptr;
                r_xfer_cnt <= r_xfer_cnt + LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_copr_mem_reader.sv
// tb_copr_mem_reader: directed tests of the port loader, with RAM models returning a tag|address word.
module tb_copr_mem_reader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start4 = 1'b0;
    logic [39:0] port_base = '0;
    logic [31:0] port_len = '0;
    logic        mem_en, busy, done;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data = '0, out_data;
    logic [3:0]  out_send, rdy = 4'hf;
    logic [3:0]  base4 = '0, mem_addr4;
    logic [7:0]  len4 = '0;
    logic        mem_en4, busy4, done4;
    logic [31:0] mem_data4 = '0, out_data4;
    logic [0:0]  send4, rdy4 = 1'b1;

    copr_mem_reader u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_port_base(port_base), .i_port_len(port_len),
        .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_data(mem_data), .o_out_data(out_data),
        .o_out_send(out_send), .i_out_rdy(rdy), .o_busy(busy), .o_done(done));

    copr_mem_reader #(.N_PORTS(1), .ADDR_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_start(start4), .i_port_base(base4), .i_port_len(len4),
        .o_mem_en(mem_en4), .o_mem_addr(mem_addr4), .i_mem_data(mem_data4), .o_out_data(out_data4),
        .o_out_send(send4), .i_out_rdy(rdy4), .o_busy(busy4), .o_done(done4));

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_en) mem_data <= 32'hA000_0000 | 32'(mem_addr);
    always @(posedge clk) if (mem_en4) mem_data4 <= 32'hB000_0000 | 32'(mem_addr4);

    int checks = 0, failures = 0;
    int cyc, issued, xfers, dones, done_cyc, onehot_bad, unstable, held, max_occ, lo_from, lo_to;
    int q_addr[$], q_icyc[$], q_port[$], q_xcyc[$];
    logic [31:0] q_data[$];
    logic        prev_held, sel4;
    logic [31:0] prev_data;
    int exp1_addr[6] = '{0, 1, 2, 32, 33, 48};
    int exp1_port[6] = '{0, 0, 0, 2, 2, 3};
    int exp1_xcyc[6] = '{4, 5, 6, 12, 13, 18};

    task automatic clr();
        issued = 0; xfers = 0; dones = 0; done_cyc = -1; onehot_bad = 0; unstable = 0;
        held = 0; max_occ = 0; lo_from = 1000; lo_to = -1; prev_held = 1'b0; prev_data = '0;
        q_addr.delete(); q_icyc.delete(); q_port.delete(); q_xcyc.delete(); q_data.delete();
    endtask

    task automatic sample();
        logic en; int a, p; logic [3:0] s, r; logic [31:0] d;
        en = sel4 ? mem_en4 : mem_en;
        a  = sel4 ? int'(mem_addr4) : int'(mem_addr);
        s  = sel4 ? {3'b0, send4} : out_send;
        r  = sel4 ? {3'b0, rdy4} : rdy;
        d  = sel4 ? out_data4 : out_data;
        p  = -1;
        for (int i = 0; i < 4; i++) if (s[i]) p = i;
        if (en) begin q_addr.push_back(a); q_icyc.push_back(cyc); issued++; end
        if (s != 4'd0) begin
            if ($countones(s) != 1) onehot_bad++;
            if (prev_held && d != prev_data) unstable++;
            if ((s & r) != 4'd0) begin
                q_port.push_back(p); q_data.push_back(d); q_xcyc.push_back(cyc); xfers++;
                prev_held = 1'b0;
            end else begin
                prev_held = 1'b1; prev_data = d; held++;
            end
        end else prev_held = 1'b0;
        if (issued - xfers > max_occ) max_occ = issued - xfers;
        if (sel4 ? done4 : done) begin dones++; done_cyc = cyc; end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            rdy  = (cyc >= lo_from && cyc <= lo_to) ? 4'b1110 : 4'b1111;
            rdy4 = (cyc >= lo_from && cyc <= lo_to) ? 1'b0 : 1'b1;
            #1;
            sample();
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic launch(input logic [39:0] b, input logic [31:0] l);
        port_base = b; port_len = l; sel4 = 1'b0; clr(); cyc = 0;
        start = 1'b1; run(1); start = 1'b0;
    endtask

    task automatic check_pass1(input string tag);
        checks++;
        if (q_addr.size() != 6 || xfers != 6) begin
            failures++; $display("FAIL %s_count addrs=%0d xfers=%0d exp=6/6", tag, q_addr.size(), xfers);
        end else
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_addr[i] != exp1_addr[i] || q_port[i] != exp1_port[i] || q_xcyc[i] != exp1_xcyc[i] ||
                    q_data[i] !== (32'hA000_0000 | 32'(exp1_addr[i]))) begin
                    failures++;
                    $display("FAIL %s_word%0d addr=%0d port=%0d cyc=%0d data=%h exp addr=%0d port=%0d cyc=%0d",
                             tag, i, q_addr[i], q_port[i], q_xcyc[i], q_data[i], exp1_addr[i], exp1_port[i], exp1_xcyc[i]);
                end
            end
        checks++;
        if (dones != 1 || done_cyc != 20) begin
            failures++; $display("FAIL %s_done pulses=%0d cyc=%0d exp=1/20", tag, dones, done_cyc);
        end
        checks++;
        if (onehot_bad != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_end onehot_bad=%0d busy=%b exp=0/0", tag, onehot_bad, busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_en, mem_addr, out_data, out_send, busy, done} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {mem_en, mem_addr, out_data, out_send, busy, done});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mem_en, out_send, busy, done, mem_en4, busy4, done4} !== '0) begin
            failures++; $display("FAIL reset_idle got=%b exp=0", {mem_en, out_send, busy, done, mem_en4, busy4, done4});
        end
    endtask

    task automatic test_sequence();
        launch({10'd48, 10'd32, 10'd16, 10'd0}, {8'd1, 8'd2, 8'd0, 8'd3});
        run(24);
        check_pass1("seq");
    endtask

    task automatic test_backpressure();
        int exp_i[5] = '{2, 3, 4, 9, 10};
        int exp_x[5] = '{4, 9, 10, 11, 12};
        port_base = '0; port_len = {8'd0, 8'd0, 8'd0, 8'd5}; sel4 = 1'b0; clr(); cyc = 0;
        lo_from = 5; lo_to = 8;
        start = 1'b1; run(1); start = 1'b0; run(22);
        checks++;
        if (q_icyc.size() != 5 || xfers != 5) begin
            failures++; $display("FAIL bp_count issues=%0d xfers=%0d exp=5/5", q_icyc.size(), xfers);
        end else
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_icyc[i] != exp_i[i] || q_addr[i] != i || q_xcyc[i] != exp_x[i] ||
                    q_data[i] !== (32'hA000_0000 | 32'(i))) begin
                    failures++;
                    $display("FAIL bp_word%0d issue_cyc=%0d addr=%0d xfer_cyc=%0d data=%h exp %0d/%0d/%0d",
                             i, q_icyc[i], q_addr[i], q_xcyc[i], q_data[i], exp_i[i], i, exp_x[i]);
                end
            end
        checks++;
        if (unstable != 0 || held != 4 || max_occ != 2) begin
            failures++; $display("FAIL bp_hold unstable=%0d held=%0d max_out=%0d exp=0/4/2", unstable, held, max_occ);
        end
        checks++;
        if (dones != 1 || done_cyc != 17) begin
            failures++; $display("FAIL bp_done pulses=%0d cyc=%0d exp=1/17", dones, done_cyc);
        end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{14, 15, 0, 1};
        base4 = 4'd14; len4 = 8'd4; sel4 = 1'b1; clr(); cyc = 0;
        start4 = 1'b1; run(1); start4 = 1'b0; run(14);
        checks++;
        if (q_addr.size() != 4 || xfers != 4) begin
            failures++; $display("FAIL wrap_count addrs=%0d xfers=%0d exp=4/4", q_addr.size(), xfers);
        end else
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_addr[i] != exp_a[i] || q_xcyc[i] != i + 4 || q_data[i] !== (32'hB000_0000 | 32'(exp_a[i]))) begin
                    failures++;
                    $display("FAIL wrap_word%0d addr=%0d cyc=%0d data=%h exp addr=%0d cyc=%0d",
                             i, q_addr[i], q_xcyc[i], q_data[i], exp_a[i], i + 4);
                end
            end
        checks++;
        if (dones != 1 || done_cyc != 9) begin
            failures++; $display("FAIL wrap_done pulses=%0d cyc=%0d exp=1/9", dones, done_cyc);
        end
        sel4 = 1'b0;
    endtask

    task automatic test_all_zero();
        launch({10'd7, 10'd6, 10'd5, 10'd4}, '0);
        run(10);
        checks++;
        if (issued != 0 || xfers != 0 || held != 0) begin
            failures++; $display("FAIL zero_traffic issues=%0d xfers=%0d held=%0d exp=0", issued, xfers, held);
        end
        checks++;
        if (dones != 1 || done_cyc != 5) begin
            failures++; $display("FAIL zero_done pulses=%0d cyc=%0d exp=1/5", dones, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        launch({10'd48, 10'd32, 10'd16, 10'd0}, {8'd1, 8'd2, 8'd0, 8'd3});
        run(4);
        rst = 1'b1; #1;
        checks++;
        if ({mem_en, mem_addr, out_data, out_send, busy, done} !== '0) begin
            failures++; $display("FAIL rstmid_outputs got=%h exp=0", {mem_en, mem_addr, out_data, out_send, busy, done});
        end
        @(posedge clk); #1; rst = 1'b0;
        clr(); cyc = 0; run(8);
        checks++;
        if (dones != 0 || issued != 0 || xfers != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_quiet done=%0d issues=%0d xfers=%0d busy=%b exp=0", dones, issued, xfers, busy);
        end
        launch({10'd48, 10'd32, 10'd16, 10'd0}, {8'd1, 8'd2, 8'd0, 8'd3});
        run(24);
        check_pass1("rerun");
    endtask

    task automatic test_restart_ignore();
        launch({10'd48, 10'd32, 10'd16, 10'd0}, {8'd1, 8'd2, 8'd0, 8'd3});
        run(5);
        start = 1'b1; port_len = {4{8'd5}}; port_base = {4{10'd100}};
        run(1);
        start = 1'b0;
        run(10);
        start = 1'b1; run(1); start = 1'b0;
        run(7);
        check_pass1("ignore");
    endtask

    initial begin
        cyc = 0; sel4 = 1'b0; clr();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sequence();
        test_backpressure();
        test_wrap();
        test_all_zero();
        test_reset_mid();
        test_restart_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
